regfile_dump_reader: RTL and testbench

- Read-side master for the register file's per-register output-enable interface.
- On `start`, walks register addresses 0..NUM_REGS-1 and drives one read select per word.
- Captures each word from the shared read bus and streams it out over a valid/ready handshake.
- Sits between the regfile and the debug/readback path, e.g. a UART framer or a hologram-pattern loader check.

---
 rtl/regfile_dump_reader.sv | 137 +++++++++++++
 tb/tb_regfile_dump_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Walks register addresses 0..NUM_REGS-1 and streams each word over a valid/ready port.
// Optional REGDUMP_CHECKSUM_EN appends an XOR checksum word after the last register.
module regfile_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_READ | rd_en high, word captured at the closing edge
  // S_SEND | captured word offered on the output port
  // S_CSUM | checksum word offered (REGDUMP_CHECKSUM_EN only)
  // S_DONE | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SEND,
`ifdef REGDUMP_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   index;
  logic                    at_last;

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   acc;
`endif

  assign at_last = (index == LAST_IDX);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b1;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_READ;
      end
      S_READ: begin
        rd_en    = 1'b1;
        rd_addr  = index;
        state_nx = S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
        if (out_ready) state_nx = at_last ? S_CSUM : S_READ;
`else
        out_last = at_last;
        if (out_ready) state_nx = at_last ? S_DONE : S_READ;
`endif
      end
`ifdef REGDUMP_CHECKSUM_EN
      S_CSUM: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        if (out_ready) state_nx = S_DONE;
      end
`endif
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // rd_data is only ever looked at in S_READ; the bus floats otherwise.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      index     <= '0;
      out_data  <= '0;
      out_index <= '0;
`ifdef REGDUMP_CHECKSUM_EN
      acc       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            index <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            acc   <= '0;
`endif
          end
        end
        S_READ: begin
          out_data  <= rd_data;
          out_index <= index;
`ifdef REGDUMP_CHECKSUM_EN
          acc       <= acc ^ rd_data;
`endif
        end
        S_SEND: begin
          if (out_ready) begin
            if (!at_last) index <= index + 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
            else          out_data <= acc;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: vector table of dump scenarios plus randomized dumps
// checked against a word-list reference built from the register contents.
module tb_regfile_dump_reader;

  localparam int DW = 32;
  localparam int N  = 32;
  localparam int AW = 5;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NOMINAL_DONE = 2 * N + 1 + CS;

  logic          clk = 1'b0;
  logic          clr;
  logic          start;
  logic          busy, done, rd_en, out_valid, out_last, out_ready;
  logic [AW-1:0] rd_addr, out_index;
  logic [DW-1:0] rd_data, out_data, junk;
  logic [DW-1:0] regs [N];

  int total = 0;
  int bad   = 0;

  regfile_dump_reader #(.DATA_WIDTH(DW), .NUM_REGS(N), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .clr(clr), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last)
  );

  // Regfile model: selected word when enabled, random garbage otherwise.
  assign rd_data = rd_en ? regs[rd_addr] : junk;

  always #5 clk = ~clk;

  typedef struct {
    int fill;
    int stall_pct;
    int stall_idx;
    int stall_len;
    int start_at;
    int clr_at;
    int exp_done;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_rd_en"}, 64'(rd_en), 0);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 0);
    chk({tag, "_out_valid"}, 64'(out_valid), 0);
    chk({tag, "_out_last"}, 64'(out_last), 0);
    chk({tag, "_out_data"}, 64'(out_data), 0);
    chk({tag, "_out_index"}, 64'(out_index), 0);
  endtask

  task automatic fill_regs(input int mode);
    for (int k = 0; k < N; k++) begin
      case (mode)
        0:       regs[k] = (DW'(k) << 27) | DW'(k);
        1:       regs[k] = DW'(k) * 32'h01010101;
        3:       regs[k] = '1;
        default: regs[k] = $urandom;
      endcase
    end
    if (mode == 4) begin
      regs[3] = 32'hDEADBEEF;
      regs[4] = 32'hCAFEBABE;
    end
  endtask

  task automatic run_dump(input vec_t v);
    logic [DW-1:0] exp_data [$];
    logic [DW-1:0] sum;
    logic [DW-1:0] p_data;
    logic [AW-1:0] p_index;
    logic          p_last;
    int            n_exp, cyc, xfers, dones, stall_left;
    bit            hold, fin;
    sum = '0;
    for (int k = 0; k < N; k++) begin
      exp_data.push_back(regs[k]);
      sum ^= regs[k];
    end
    if (CS != 0) exp_data.push_back(sum);
    n_exp = N + CS;
    cyc = 0; xfers = 0; dones = 0; stall_left = v.stall_len; hold = 0; fin = 0;
    p_data = '0; p_index = '0; p_last = 1'b0;

    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b0;
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      junk = $urandom;
      #1;
      if (v.clr_at >= 0 && out_valid && xfers == v.clr_at) begin
        junk = '1;
        clr = 1'b1;
        #1;
        chk_idle_zero("clr_mid");
        chk("clr_mid_no_done", 64'(dones), 0);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk_idle_zero("after_clr");
        end
        return;
      end
      chk("busy_during_dump", 64'(busy), 1);
      if (hold) begin
        chk("hold_valid", 64'(out_valid), 1);
        chk("hold_data", 64'(out_data), 64'(p_data));
        chk("hold_index", 64'(out_index), 64'(p_index));
        chk("hold_last", 64'(out_last), 64'(p_last));
      end
      if (rd_en) chk("rd_addr_order", 64'(rd_addr), 64'(xfers));
      if (out_valid) begin
        chk("last_flag", 64'(out_last), 64'(xfers == n_exp - 1));
        if (xfers == v.stall_idx && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = ($urandom_range(99) >= v.stall_pct);
        end
        hold = !out_ready;
        p_data = out_data; p_index = out_index; p_last = out_last;
        if (out_ready) begin
          chk("word_data", 64'(out_data), 64'(exp_data[xfers]));
          chk("word_index", 64'(out_index), 64'((xfers < N) ? xfers : N - 1));
          if (xfers == v.start_at) start = 1'b1;
          xfers++;
        end
      end else begin
        hold = 0;
        chk("last_low_idle", 64'(out_last), 0);
        out_ready = 1'($urandom_range(1));
      end
      if (done) begin
        dones++;
        if (v.exp_done > 0) chk("done_cycle", 64'(cyc), 64'(v.exp_done));
        chk("word_count", 64'(xfers), 64'(n_exp));
        fin = 1;
      end
    end
    chk("dump_finished", 64'(fin), 1);
    @(negedge clk);
    #1;
    chk("post_busy", 64'(busy), 0);
    chk("post_done", 64'(done), 0);
    chk("post_rd_en", 64'(rd_en), 0);
    chk("done_count", 64'(dones), 1);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; out_ready = 1'b0; junk = '1;
    fill_regs(0);
    #12;
    chk_idle_zero("reset");
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk_idle_zero("reset_release");

    //           fill pct sidx slen stat clr done
    vecs[0] = '{ 0,   0,  -1,  0,  -1,  -1, NOMINAL_DONE };
    vecs[1] = '{ 4,   0,   3,  7,  -1,  -1, NOMINAL_DONE + 7 };
    vecs[2] = '{ 1,   0,  -1,  0,  10,  -1, NOMINAL_DONE };
    vecs[3] = '{ 2,  40,  -1,  0,  -1,  -1, -1 };
    vecs[4] = '{ 3,   0,  -1,  0,  -1,  15, -1 };
    vecs[5] = '{ 0,   0,  -1,  0,  -1,  -1, NOMINAL_DONE };
    vecs[6] = '{ 2,  70,   5,  3,  20,  -1, -1 };
    for (int i = 0; i < 7; i++) begin
      fill_regs(vecs[i].fill);
      run_dump(vecs[i]);
    end

    for (int r = 0; r < 4; r++) begin
      vec_t rv;
      rv = '{ 2, int'($urandom_range(60)), int'($urandom_range(N - 1)),
              int'($urandom_range(5)), int'($urandom_range(N - 1)), -1, -1 };
      fill_regs(2);
      run_dump(rv);
    end

    // start held high: one IDLE cycle between back-to-back dumps
    begin
      int c;
      fill_regs(0);
      @(negedge clk);
      start = 1'b1;
      out_ready = 1'b1;
      c = 0;
      @(negedge clk);
      while (!done && c < 500) begin
        @(negedge clk);
        c++;
      end
      chk("held_done_seen", 64'(done), 1);
      @(negedge clk);
      chk("held_gap_busy", 64'(busy), 0);
      chk("held_gap_rd_en", 64'(rd_en), 0);
      @(negedge clk);
      chk("held_restart_rd_en", 64'(rd_en), 1);
      chk("held_restart_addr", 64'(rd_addr), 0);
      start = 1'b0;
      clr = 1'b1;
      #1;
      chk_idle_zero("held_clr");
      clr = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
